// File: rtl/calc1.sv
// calc1: four independent 32-bit unsigned calculator ports, each taking a
// two-cycle command (cmd + op1, then op2) and returning a one-cycle response.

module calc1_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  cmd_i,
  input  logic [31:0] data_i,
  output logic [1:0]  resp_o,
  output logic [31:0] data_o
);

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_OVF  = 2'd2;
  localparam logic [1:0] RESP_INV  = 2'd3;

  localparam logic [3:0] CMD_ADD = 4'd1;
  localparam logic [3:0] CMD_SUB = 4'd2;
  localparam logic [3:0] CMD_SHL = 4'd5;
  localparam logic [3:0] CMD_SHR = 4'd6;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OP2  = 2'd1,
    ST_EXEC = 2'd2
  } state_t;

  state_t      state_q;
  logic [3:0]  cmd_q;
  logic [31:0] op1_q;
  logic [1:0]  resp_q;
  logic [31:0] result_q;

  logic [1:0]  resp_d;
  logic [31:0] result_d;
  logic [32:0] sum_d;

  // op2 is consumed straight from the data input during OP2, so the result is
  // computed that cycle and lands in the output register on the OP2->EXEC edge.
  always_comb begin
    resp_d   = RESP_INV;
    result_d = 32'd0;
    sum_d    = {1'b0, op1_q} + {1'b0, data_i};
    case (cmd_q)
      CMD_ADD: begin
        if (sum_d[32]) begin
          resp_d = RESP_OVF;
        end else begin
          resp_d   = RESP_OK;
          result_d = sum_d[31:0];
        end
      end
      CMD_SUB: begin
        if (op1_q < data_i) begin
          resp_d = RESP_OVF;
        end else begin
          resp_d   = RESP_OK;
          result_d = op1_q - data_i;
        end
      end
      CMD_SHL: begin
        resp_d   = RESP_OK;
        result_d = op1_q << data_i[4:0];
      end
      CMD_SHR: begin
        resp_d   = RESP_OK;
        result_d = op1_q >> data_i[4:0];
      end
      default: begin
        resp_d   = RESP_INV;
        result_d = 32'd0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cmd_q    <= 4'd0;
      op1_q    <= 32'd0;
      resp_q   <= RESP_NONE;
      result_q <= 32'd0;
    end else begin
      case (state_q)
        // EXEC doubles as an accept slot so commands can issue every 2 cycles.
        ST_IDLE, ST_EXEC: begin
          resp_q   <= RESP_NONE;
          result_q <= 32'd0;
          if (cmd_i != 4'd0) begin
            cmd_q   <= cmd_i;
            op1_q   <= data_i;
            state_q <= ST_OP2;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_OP2: begin
          resp_q   <= resp_d;
          result_q <= result_d;
          state_q  <= ST_EXEC;
        end
        default: begin
          resp_q   <= RESP_NONE;
          result_q <= 32'd0;
          state_q  <= ST_IDLE;
        end
      endcase
    end
  end

  assign resp_o = resp_q;
  assign data_o = result_q;

endmodule

module calc1 (
  input  logic        c_clk,
  input  logic        reset,
  input  logic [3:0]  req1_cmd_in,
  input  logic [31:0] req1_data_in,
  input  logic [3:0]  req2_cmd_in,
  input  logic [31:0] req2_data_in,
  input  logic [3:0]  req3_cmd_in,
  input  logic [31:0] req3_data_in,
  input  logic [3:0]  req4_cmd_in,
  input  logic [31:0] req4_data_in,
  output logic [1:0]  out_resp1,
  output logic [31:0] out_data1,
  output logic [1:0]  out_resp2,
  output logic [31:0] out_data2,
  output logic [1:0]  out_resp3,
  output logic [31:0] out_data3,
  output logic [1:0]  out_resp4,
  output logic [31:0] out_data4
);

  logic [3:0]  cmd_arr  [4];
  logic [31:0] din_arr  [4];
  logic [1:0]  resp_arr [4];
  logic [31:0] dout_arr [4];

  assign cmd_arr[0] = req1_cmd_in;
  assign cmd_arr[1] = req2_cmd_in;
  assign cmd_arr[2] = req3_cmd_in;
  assign cmd_arr[3] = req4_cmd_in;
  assign din_arr[0] = req1_data_in;
  assign din_arr[1] = req2_data_in;
  assign din_arr[2] = req3_data_in;
  assign din_arr[3] = req4_data_in;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_port
      calc1_port u_port (
        .clk    (c_clk),
        .rst_n  (reset),
        .cmd_i  (cmd_arr[gi]),
        .data_i (din_arr[gi]),
        .resp_o (resp_arr[gi]),
        .data_o (dout_arr[gi])
      );
    end
  endgenerate

  assign out_resp1 = resp_arr[0];
  assign out_resp2 = resp_arr[1];
  assign out_resp3 = resp_arr[2];
  assign out_resp4 = resp_arr[3];
  assign out_data1 = dout_arr[0];
  assign out_data2 = dout_arr[1];
  assign out_data3 = dout_arr[2];
  assign out_data4 = dout_arr[3];

endmodule

// File: tb/tb_calc1.sv
// Scoreboard bench for calc1: expected responses are queued at issue time and
// matched against every non-idle output cycle the monitor records.

module tb_calc1;

  typedef struct {
    int          cyc;
    logic [1:0]  resp;
    logic [31:0] data;
  } ent_t;

  logic        c_clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  cmd      [4];
  logic [31:0] din      [4];
  logic [1:0]  resp     [4];
  logic [31:0] dout     [4];
  logic        pend     [4];
  logic        junk_ok  [4];
  logic [31:0] op2_pend [4];
  ent_t        exp_q    [4][$];
  ent_t        obs_q    [4][$];
  int          cyc = 0;
  int          pass_cnt = 0;
  int          total_cnt = 0;

  calc1 dut (
    .c_clk        (c_clk),
    .reset        (reset),
    .req1_cmd_in  (cmd[0]),
    .req1_data_in (din[0]),
    .req2_cmd_in  (cmd[1]),
    .req2_data_in (din[1]),
    .req3_cmd_in  (cmd[2]),
    .req3_data_in (din[2]),
    .req4_cmd_in  (cmd[3]),
    .req4_data_in (din[3]),
    .out_resp1    (resp[0]),
    .out_data1    (dout[0]),
    .out_resp2    (resp[1]),
    .out_data2    (dout[1]),
    .out_resp3    (resp[2]),
    .out_data3    (dout[2]),
    .out_resp4    (resp[3]),
    .out_data4    (dout[3])
  );

  always #5 c_clk = ~c_clk;
  always @(posedge c_clk) cyc <= cyc + 1;

  // Any cycle with a nonzero response or data is recorded for the scoreboard.
  always @(negedge c_clk) begin
    for (int p = 0; p < 4; p++) begin
      if (resp[p] !== 2'd0 || dout[p] !== 32'd0)
        obs_q[p].push_back('{cyc, resp[p], dout[p]});
    end
  end

  // Advance one cycle; ports with a pending command get op2 and a junk cmd.
  task automatic next_cycle();
    @(posedge c_clk);
    #1;
    for (int p = 0; p < 4; p++) begin
      if (pend[p]) begin
        din[p]  = op2_pend[p];
        cmd[p]  = junk_ok[p] ? 4'($urandom) : 4'd0;
        pend[p] = 1'b0;
      end else begin
        cmd[p] = 4'd0;
        din[p] = $urandom;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) next_cycle();
  endtask

  task automatic launch(input int p, input logic [3:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
    cmd[p]      = c;
    din[p]      = a;
    pend[p]     = 1'b1;
    op2_pend[p] = b;
    junk_ok[p]  = (c != 4'd0);
    if (c != 4'd0) exp_q[p].push_back('{cyc + 2, er, ed});
  endtask

  task automatic cmd1(input int p, input logic [3:0] c, input logic [31:0] a,
                      input logic [31:0] b, input logic [1:0] er, input logic [31:0] ed);
    next_cycle();
    launch(p, c, a, b, er, ed);
    next_cycle();
  endtask

  function automatic ent_t model(input logic [3:0] c, input logic [31:0] a,
                                 input logic [31:0] b, input int when);
    ent_t e;
    e.cyc  = when;
    e.resp = 2'd3;
    e.data = 32'd0;
    case (c)
      4'd1: if (a > 32'hFFFF_FFFF - b) e.resp = 2'd2; else begin e.resp = 2'd1; e.data = a + b; end
      4'd2: if (a < b) e.resp = 2'd2; else begin e.resp = 2'd1; e.data = a - b; end
      4'd5: begin e.resp = 2'd1; e.data = a << (b % 32); end
      4'd6: begin e.resp = 2'd1; e.data = a >> (b % 32); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 7; i++) begin
      @(posedge c_clk);
      #1;
      for (int p = 0; p < 4; p++) begin
        cmd[p] = 4'($urandom | 32'd1);
        din[p] = $urandom;
      end
    end
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (resp[p] !== 2'd0) $display("FAIL reset_resp port%0d: got %0d expected 0", p, resp[p]);
      else pass_cnt++;
      total_cnt++;
      if (dout[p] !== 32'd0) $display("FAIL reset_data port%0d: got %h expected 0", p, dout[p]);
      else pass_cnt++;
      cmd[p] = 4'd0;
    end
    @(posedge c_clk);
    #1;
    reset = 1'b1;
    idle(4);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL reset_quiet port%0d: got %0d responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_nop();
    cmd1(0, 4'd0, 32'h64, 32'h27, 2'd0, 32'd0);
    idle(10);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL nop port%0d: got %0d responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_add();
    ent_t e, o;
    cmd1(0, 4'd1, 32'h64, 32'h27, 2'd1, 32'h8B);
    cmd1(0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd2, 32'd0);
    cmd1(0, 4'd1, 32'hFFFF_FFFF, 32'h0, 2'd1, 32'hFFFF_FFFF);
    cmd1(0, 4'd1, 32'h8000_0000, 32'h8000_0000, 2'd2, 32'd0);
    cmd1(0, 4'd1, 32'h7FFF_FFFF, 32'h8000_0000, 2'd1, 32'hFFFF_FFFF);
    idle(4);
    for (int p = 0; p < 4; p++) begin
      while (exp_q[p].size() > 0) begin
        e = exp_q[p].pop_front();
        total_cnt++;
        if (obs_q[p].size() == 0) $display("FAIL add port%0d: got no response expected cyc %0d resp %0d data %h", p, e.cyc, e.resp, e.data);
        else begin
          o = obs_q[p].pop_front();
          if (o.cyc !== e.cyc || o.resp !== e.resp || o.data !== e.data)
            $display("FAIL add port%0d: got cyc %0d resp %0d data %h expected cyc %0d resp %0d data %h", p, o.cyc, o.resp, o.data, e.cyc, e.resp, e.data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL add_extra port%0d: got %0d extra responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_sub();
    ent_t e, o;
    cmd1(0, 4'd2, 32'h5, 32'h2, 2'd1, 32'h3);
    cmd1(0, 4'd2, 32'h22, 32'h23, 2'd2, 32'd0);
    cmd1(0, 4'd2, 32'h1234, 32'h1234, 2'd1, 32'd0);
    cmd1(0, 4'd2, 32'h0, 32'hFFFF_FFFF, 2'd2, 32'd0);
    cmd1(0, 4'd2, 32'hFFFF_FFFF, 32'h1, 2'd1, 32'hFFFF_FFFE);
    idle(4);
    for (int p = 0; p < 4; p++) begin
      while (exp_q[p].size() > 0) begin
        e = exp_q[p].pop_front();
        total_cnt++;
        if (obs_q[p].size() == 0) $display("FAIL sub port%0d: got no response expected cyc %0d resp %0d data %h", p, e.cyc, e.resp, e.data);
        else begin
          o = obs_q[p].pop_front();
          if (o.cyc !== e.cyc || o.resp !== e.resp || o.data !== e.data)
            $display("FAIL sub port%0d: got cyc %0d resp %0d data %h expected cyc %0d resp %0d data %h", p, o.cyc, o.resp, o.data, e.cyc, e.resp, e.data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL sub_extra port%0d: got %0d extra responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_shift();
    ent_t e, o;
    cmd1(2, 4'd5, 32'h3, 32'd2, 2'd1, 32'hC);
    cmd1(2, 4'd6, 32'hC, 32'd2, 2'd1, 32'h3);
    cmd1(2, 4'd5, 32'h8000_0001, 32'd33, 2'd1, 32'h0000_0002);
    cmd1(2, 4'd5, 32'hDEAD_BEEF, 32'd0, 2'd1, 32'hDEAD_BEEF);
    cmd1(2, 4'd6, 32'hDEAD_BEEF, 32'h0000_0020, 2'd1, 32'hDEAD_BEEF);
    cmd1(2, 4'd5, 32'hFFFF_FFFF, 32'd31, 2'd1, 32'h8000_0000);
    cmd1(2, 4'd6, 32'hFFFF_FFFF, 32'd31, 2'd1, 32'h0000_0001);
    cmd1(2, 4'd6, 32'h8000_0001, 32'd33, 2'd1, 32'h4000_0000);
    idle(4);
    for (int p = 0; p < 4; p++) begin
      while (exp_q[p].size() > 0) begin
        e = exp_q[p].pop_front();
        total_cnt++;
        if (obs_q[p].size() == 0) $display("FAIL shift port%0d: got no response expected cyc %0d resp %0d data %h", p, e.cyc, e.resp, e.data);
        else begin
          o = obs_q[p].pop_front();
          if (o.cyc !== e.cyc || o.resp !== e.resp || o.data !== e.data)
            $display("FAIL shift port%0d: got cyc %0d resp %0d data %h expected cyc %0d resp %0d data %h", p, o.cyc, o.resp, o.data, e.cyc, e.resp, e.data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL shift_extra port%0d: got %0d extra responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_invalid();
    ent_t e, o;
    cmd1(1, 4'd3, 32'h1111, 32'h2222, 2'd3, 32'd0);
    cmd1(1, 4'hF, 32'hFFFF_FFFF, 32'h1, 2'd3, 32'd0);
    cmd1(1, 4'd4, 32'h5, 32'h5, 2'd3, 32'd0);
    cmd1(1, 4'd7, 32'h5, 32'h5, 2'd3, 32'd0);
    cmd1(1, 4'd1, 32'h10, 32'h20, 2'd1, 32'h30);
    idle(4);
    for (int p = 0; p < 4; p++) begin
      while (exp_q[p].size() > 0) begin
        e = exp_q[p].pop_front();
        total_cnt++;
        if (obs_q[p].size() == 0) $display("FAIL invalid port%0d: got no response expected cyc %0d resp %0d data %h", p, e.cyc, e.resp, e.data);
        else begin
          o = obs_q[p].pop_front();
          if (o.cyc !== e.cyc || o.resp !== e.resp || o.data !== e.data)
            $display("FAIL invalid port%0d: got cyc %0d resp %0d data %h expected cyc %0d resp %0d data %h", p, o.cyc, o.resp, o.data, e.cyc, e.resp, e.data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL invalid_extra port%0d: got %0d extra responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_back_to_back();
    ent_t        e, o;
    logic [3:0]  ops [4];
    logic [3:0]  c;
    logic [31:0] a, b;
    ops[0] = 4'd1; ops[1] = 4'd2; ops[2] = 4'd5; ops[3] = 4'd6;
    for (int r = 0; r < 8; r++) begin
      next_cycle();
      for (int p = 0; p < 4; p++) begin
        c = ops[(p + r) % 4];
        a = (r % 2 == 0) ? $urandom : 32'($urandom_range(1000, 5000));
        b = (r % 2 == 0) ? $urandom : 32'($urandom_range(0, 999));
        e = model(c, a, b, cyc + 2);
        launch(p, c, a, b, e.resp, e.data);
      end
      next_cycle();
    end
    idle(4);
    for (int p = 0; p < 4; p++) begin
      while (exp_q[p].size() > 0) begin
        e = exp_q[p].pop_front();
        total_cnt++;
        if (obs_q[p].size() == 0) $display("FAIL b2b port%0d: got no response expected cyc %0d resp %0d data %h", p, e.cyc, e.resp, e.data);
        else begin
          o = obs_q[p].pop_front();
          if (o.cyc !== e.cyc || o.resp !== e.resp || o.data !== e.data)
            $display("FAIL b2b port%0d: got cyc %0d resp %0d data %h expected cyc %0d resp %0d data %h", p, o.cyc, o.resp, o.data, e.cyc, e.resp, e.data);
          else pass_cnt++;
        end
      end
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL b2b_extra port%0d: got %0d extra responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    // Reset pulsed during OP2: the in-flight commands must vanish.
    next_cycle();
    for (int p = 0; p < 4; p++) launch(p, 4'd1, 32'h5, 32'h6, 2'd1, 32'hB);
    next_cycle();
    for (int p = 0; p < 4; p++) cmd[p] = 4'd0;
    reset = 1'b0;
    #2;
    reset = 1'b1;
    for (int p = 0; p < 4; p++) exp_q[p].delete();
    idle(6);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL reset_op2 port%0d: got %0d responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
    // Reset during EXEC: the visible response must drop at once.
    next_cycle();
    for (int p = 0; p < 4; p++) launch(p, 4'd2, 32'h9, 32'h4, 2'd1, 32'h5);
    next_cycle();
    next_cycle();
    reset = 1'b0;
    #1;
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (resp[p] !== 2'd0 || dout[p] !== 32'd0)
        $display("FAIL reset_exec port%0d: got resp %0d data %h expected resp 0 data 0", p, resp[p], dout[p]);
      else pass_cnt++;
    end
    #1;
    reset = 1'b1;
    for (int p = 0; p < 4; p++) exp_q[p].delete();
    idle(6);
    for (int p = 0; p < 4; p++) begin
      total_cnt++;
      if (obs_q[p].size() != 0) begin
        $display("FAIL reset_exec_quiet port%0d: got %0d responses expected 0", p, obs_q[p].size());
        obs_q[p].delete();
      end else pass_cnt++;
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin
      cmd[p]      = 4'd0;
      din[p]      = 32'd0;
      pend[p]     = 1'b0;
      junk_ok[p]  = 1'b0;
      op2_pend[p] = 32'd0;
    end
    test_reset();
    test_nop();
    test_add();
    test_sub();
    test_shift();
    test_invalid();
    test_back_to_back();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
